rx_packet_deframer: RTL and testbench

- Sits directly downstream of the 8b10b receiver and consumes its decoded byte stream: byte, valid strobe and comma reframe pulse.
- Parses each packet as LEN, SEQ, LEN payload bytes, CHK, and checks its length and checksum.
- Stores the payload in a store-and-forward FIFO, releasing good packets to a ready/valid consumer and discarding bad ones in full.

---
 rtl/rx_packet_deframer_pkg.sv | 20 ++
 rtl/rx_pkt_fifo.sv | 69 ++++++
 rtl/rx_packet_deframer.sv | 182 ++++++++++++++++++
 tb/tb_rx_packet_deframer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_packet_deframer_pkg.sv
// Shared encodings for the packet deframer: parser states and drop-cause codes.
// Both the deframer top and its payload FIFO import this package.
package rx_packet_deframer_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SEQ     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_ABORT    = 2'd0,
        ERR_BADLEN   = 2'd1,
        ERR_CHKSUM   = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_t;

endpackage

// File: rtl/rx_pkt_fifo.sv
// Store-and-forward payload FIFO with separate write, commit and read pointers.
// Uncommitted bytes can be rewound without disturbing committed data.
module rx_pkt_fifo
    import rx_packet_deframer_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr_en,
    input  logic [8:0] i_wr_data,
    input  logic       i_commit,
    input  logic       i_rewind,
    input  logic       i_rd_ready,
    output logic [8:0] o_rd_data,
    output logic       o_valid,
    output logic       o_full
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_cm_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [8:0]      r_mem [DEPTH];

    logic [ADDR_W:0] w_used;
    logic            w_wr_fire;
    logic            w_rd_fire;

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign o_full    = (w_used == FULL_CNT);
    assign o_valid   = (r_rd_ptr != r_cm_ptr);
    assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign w_wr_fire = i_wr_en && !o_full;
    assign w_rd_fire = o_valid && i_rd_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_rewind) begin
                r_wr_ptr <= r_cm_ptr;
            end else if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_commit) begin
                r_cm_ptr <= r_wr_ptr;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; pointers alone define which
    // entries are meaningful, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/rx_packet_deframer.sv
// Parses LEN/SEQ/payload/CHK packets from the 8b10b byte stream, checks length
// and checksum, and releases only good payloads through the store-and-forward FIFO.
module rx_packet_deframer
    import rx_packet_deframer_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int MAX_LEN = 32
) (
    input  logic       clk_x8,
    input  logic       rst_n,
    input  logic [7:0] d_in,
    input  logic       d_in_valid,
    input  logic       reframe,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic [7:0] pkt_seq,
    output logic       synced
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     r_state;
    logic [7:0] r_sum;
    logic [7:0] r_rem;
    logic [7:0] r_seq;
    logic       r_ovf;
    logic       r_pkt_ok;
    logic       r_pkt_err;
    err_t       r_err_code;
    logic [7:0] r_pkt_seq;

    state_t     w_state_nxt;
    logic [7:0] w_sum_nxt;
    logic [7:0] w_rem_nxt;
    logic [7:0] w_seq_nxt;
    logic       w_ovf_nxt;
    logic [7:0] w_sum_add;
    logic       w_wr_en;
    logic       w_commit;
    logic       w_rewind;
    logic       w_ok;
    logic       w_err;
    err_t       w_err_cause;
    logic       w_full;
    logic [8:0] w_rd_data;

    assign w_sum_add = r_sum + d_in;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_rem_nxt   = r_rem;
        w_seq_nxt   = r_seq;
        w_ovf_nxt   = r_ovf;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_rewind    = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_err_cause = ERR_ABORT;

        if (reframe) begin
            // A comma resynchronises; any packet in flight is abandoned.
            unique case (r_state)
                ST_HUNT, ST_IDLE: w_state_nxt = ST_IDLE;
                default: begin
                    w_err       = 1'b1;
                    w_err_cause = ERR_ABORT;
                    w_rewind    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (d_in_valid) begin
            unique case (r_state)
                ST_HUNT: ;
                ST_IDLE: begin
                    if (d_in != 8'd0 && d_in <= MAX_LEN_B) begin
                        w_rem_nxt   = d_in;
                        w_sum_nxt   = d_in;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = ST_SEQ;
                    end else begin
                        w_err       = 1'b1;
                        w_err_cause = ERR_BADLEN;
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_SEQ: begin
                    w_seq_nxt   = d_in;
                    w_sum_nxt   = w_sum_add;
                    w_state_nxt = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    w_sum_nxt = w_sum_add;
                    w_rem_nxt = r_rem - 1'b1;
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                    if (r_rem == 8'd1) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    w_sum_nxt   = w_sum_add;
                    w_state_nxt = ST_IDLE;
                    if (r_ovf) begin
                        w_err       = 1'b1;
                        w_err_cause = ERR_OVERFLOW;
                        w_rewind    = 1'b1;
                    end else if (w_sum_add != 8'd0) begin
                        w_err       = 1'b1;
                        w_err_cause = ERR_CHKSUM;
                        w_rewind    = 1'b1;
                    end else begin
                        w_ok     = 1'b1;
                        w_commit = 1'b1;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_x8 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_sum      <= '0;
            r_rem      <= '0;
            r_seq      <= '0;
            r_ovf      <= 1'b0;
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= ERR_ABORT;
            r_pkt_seq  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sum     <= w_sum_nxt;
            r_rem     <= w_rem_nxt;
            r_seq     <= w_seq_nxt;
            r_ovf     <= w_ovf_nxt;
            r_pkt_ok  <= w_ok;
            r_pkt_err <= w_err;
            if (w_err) begin
                r_err_code <= w_err_cause;
            end
            if (w_ok) begin
                r_pkt_seq <= r_seq;
            end
        end
    end

    rx_pkt_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk_x8),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_data  ({r_rem == 8'd1, d_in}),
        .i_commit   (w_commit),
        .i_rewind   (w_rewind),
        .i_rd_ready (m_ready),
        .o_rd_data  (w_rd_data),
        .o_valid    (m_valid),
        .o_full     (w_full)
    );

    assign {m_last, m_data} = w_rd_data;
    assign pkt_ok   = r_pkt_ok;
    assign pkt_err  = r_pkt_err;
    assign err_code = r_err_code;
    assign pkt_seq  = r_pkt_seq;
    assign synced   = (r_state != ST_HUNT);

endmodule

// File: tb/tb_rx_packet_deframer.sv
// Directed bench for rx_packet_deframer with a small 8-entry FIFO so overflow
// and pointer wrap are reachable; expected payloads come from the bench's own packet list.
module tb_rx_packet_deframer;

    localparam int ADDR_W  = 3;
    localparam int MAX_LEN = 8;

    logic       clk_x8     = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] d_in       = '0;
    logic       d_in_valid = 1'b0;
    logic       reframe    = 1'b0;
    logic       m_ready    = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic [7:0] pkt_seq;
    logic       synced;

    rx_packet_deframer #(
        .ADDR_W  (ADDR_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk_x8     (clk_x8),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .d_in_valid (d_in_valid),
        .reframe    (reframe),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .pkt_seq    (pkt_seq),
        .synced     (synced)
    );

    always #5 clk_x8 = ~clk_x8;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ok_cnt  = 0;
    int         err_cnt = 0;
    logic [1:0] last_err = 2'd0;
    bit         mv_seen = 1'b0;
    bit         rnd_ready = 1'b0;
    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] pl_q  [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk_x8) begin
        if (rst_n) begin
            if (pkt_ok) ok_cnt++;
            if (pkt_err) begin
                err_cnt++;
                last_err = err_code;
            end
            if (m_valid) mv_seen = 1'b1;
            if (m_valid && m_ready) got_q.push_back({m_last, m_data});
        end
    end

    always @(posedge clk_x8) begin
        if (rnd_ready) begin
            #1 m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_x8);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        d_in       = b;
        d_in_valid = 1'b1;
        @(posedge clk_x8);
        #1;
        d_in_valid = 1'b0;
    endtask

    task automatic do_reframe();
        reframe = 1'b1;
        @(posedge clk_x8);
        #1;
        reframe = 1'b0;
    endtask

    task automatic clear_mon();
        ok_cnt  = 0;
        err_cnt = 0;
        mv_seen = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    // Sends pl_q framed as a packet; deliver says whether the bench expects it out.
    task automatic send_pkt(input logic [7:0] seq, input bit corrupt, input bit deliver);
        logic [7:0] len;
        logic [7:0] s;
        logic [7:0] chk;
        len = 8'(pl_q.size());
        s   = len + seq;
        foreach (pl_q[i]) s = s + pl_q[i];
        chk = 8'd0 - s;
        if (corrupt) chk = chk + 8'd1;
        send_byte(len);
        send_byte(seq);
        foreach (pl_q[i]) send_byte(pl_q[i]);
        send_byte(chk);
        if (deliver && !corrupt) begin
            foreach (pl_q[i]) exp_q.push_back({(i == pl_q.size() - 1), pl_q[i]});
        end
    endtask

    task automatic load_fixed(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pl_q.delete();
        pl_q.push_back(a);
        pl_q.push_back(b);
        pl_q.push_back(c);
    endtask

    task automatic load_random(input int lo, input int hi);
        int n;
        n = $urandom_range(lo, hi);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (m_valid && n < 400) begin
            @(posedge clk_x8);
            #1;
            n++;
        end
        check(tag, 32'(n < 400), 32'd1);
    endtask

    task automatic compare_q(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        int n_good;
        int n_last;

        // Reset values
        idle(3);
        check("rst_m_valid", m_valid, 0);
        check("rst_synced", synced, 0);
        check("rst_pkt_ok", pkt_ok, 0);
        check("rst_pkt_err", pkt_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_pkt_seq", pkt_seq, 0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        idle(2);

        // No comma yet: everything is ignored
        clear_mon();
        load_fixed(8'h10, 8'h20, 8'h30);
        send_pkt(8'h01, 1'b0, 1'b0);
        idle(3);
        check("hunt_synced", synced, 0);
        check("hunt_ok", ok_cnt, 0);
        check("hunt_err", err_cnt, 0);
        check("hunt_valid", mv_seen, 0);

        // Good packet 03 01 10 20 30 9C
        do_reframe();
        check("sync_after_comma", synced, 1);
        clear_mon();
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h30); send_byte(8'h9C);
        exp_q.push_back(9'h010); exp_q.push_back(9'h020); exp_q.push_back(9'h130);
        idle(6);
        check("good_ok", ok_cnt, 1);
        check("good_seq", pkt_seq, 8'h01);
        compare_q("good");

        // Bad checksum, then a good packet
        clear_mon();
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h30); send_byte(8'h9D);
        idle(4);
        check("chk_err", err_cnt, 1);
        check("chk_code", last_err, 2);
        check("chk_no_valid", mv_seen, 0);
        check("chk_rewind", 32'(dut.u_fifo.r_wr_ptr), 32'(dut.u_fifo.r_cm_ptr));
        pl_q.delete(); pl_q.push_back(8'hAA); pl_q.push_back(8'h55);
        send_pkt(8'h02, 1'b0, 1'b1);
        idle(5);
        check("chk_next_ok", ok_cnt, 1);
        check("chk_next_seq", pkt_seq, 8'h02);
        compare_q("after_chk");

        // Abort mid-packet
        clear_mon();
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h10);
        do_reframe();
        idle(4);
        check("abort_err", err_cnt, 1);
        check("abort_code", last_err, 0);
        check("abort_no_valid", mv_seen, 0);
        check("abort_synced", synced, 1);

        // Bad lengths 0 and MAX_LEN+1
        clear_mon();
        send_byte(8'h00);
        idle(1);
        check("len0_err", err_cnt, 1);
        check("len0_code", last_err, 1);
        check("len0_synced", synced, 0);
        load_fixed(8'h10, 8'h20, 8'h30);
        send_pkt(8'h05, 1'b0, 1'b0);
        idle(3);
        check("len0_ignored_ok", ok_cnt, 0);
        check("len0_ignored_err", err_cnt, 1);
        do_reframe();
        send_byte(8'(MAX_LEN + 1));
        idle(1);
        check("lenmax_err", err_cnt, 2);
        check("lenmax_code", last_err, 1);
        check("lenmax_synced", synced, 0);
        check("lenmax_no_valid", mv_seen, 0);
        do_reframe();

        // Overflow: 5 committed bytes leave room for only 3 more
        m_ready = 1'b0;
        clear_mon();
        pl_q.delete();
        for (int i = 0; i < 5; i++) pl_q.push_back(8'(8'hA0 + i));
        send_pkt(8'h10, 1'b0, 1'b1);
        pl_q.delete();
        for (int i = 0; i < 5; i++) pl_q.push_back(8'(8'hB0 + i));
        send_pkt(8'h11, 1'b0, 1'b0);
        idle(2);
        check("ovf_ok", ok_cnt, 1);
        check("ovf_err", err_cnt, 1);
        check("ovf_code", last_err, 3);
        check("ovf_seq", pkt_seq, 8'h10);
        check("ovf_rewind", 32'(dut.u_fifo.r_wr_ptr), 32'(dut.u_fifo.r_cm_ptr));
        m_ready = 1'b1;
        wait_drain("ovf_drain");
        compare_q("ovf");

        // 40 random good packets with pointer wrap
        clear_mon();
        for (int p = 0; p < 40; p++) begin
            load_random(1, MAX_LEN);
            send_pkt(8'(p), 1'b0, 1'b1);
            wait_drain("stream_drain");
        end
        check("stream_ok", ok_cnt, 40);
        compare_q("stream");

        // Back-to-back pairs under random backpressure, some corrupted
        clear_mon();
        n_good = 0;
        rnd_ready = 1'b1;
        for (int p = 0; p < 15; p++) begin
            load_random(1, 3);
            send_pkt(8'(2 * p), 1'b0, 1'b1);
            n_good++;
            load_random(1, 3);
            if ($urandom_range(0, 3) == 0) begin
                send_pkt(8'(2 * p + 1), 1'b1, 1'b0);
            end else begin
                send_pkt(8'(2 * p + 1), 1'b0, 1'b1);
                n_good++;
            end
            wait_drain("bp_drain");
        end
        rnd_ready = 1'b0;
        idle(2);
        m_ready = 1'b1;
        idle(2);
        n_last = 0;
        foreach (got_q[i]) if (got_q[i][8]) n_last++;
        check("bp_ok", ok_cnt, n_good);
        check("bp_last", n_last, n_good);
        compare_q("bp");

        // Reset mid-packet discards committed and pending bytes
        m_ready = 1'b0;
        load_fixed(8'h11, 8'h22, 8'h33);
        send_pkt(8'h40, 1'b0, 1'b0);
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h10);
        check("pre_rst_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_synced", synced, 0);
        check("mid_rst_wr", 32'(dut.u_fifo.r_wr_ptr), 0);
        check("mid_rst_seq", pkt_seq, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
